// File: rtl/mult_share_pkg.sv
// Shared helpers for the time-shared multiplier arbiter.
package mult_share_pkg;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bit position of the result LSB inside the full product.
    function automatic int lsb_of(input int in_pt, input int out_pt);
        return 2 * in_pt - out_pt;
    endfunction

    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Operand/result handshake bundle between requesters and the arbiter.
interface mult_share_arbiter_if #(
    parameter int Width  = 16,
    parameter int NumReq = 4
);
    logic [NumReq-1:0]       req_valid_i;
    logic [NumReq*Width-1:0] req_a_i;
    logic [NumReq*Width-1:0] req_b_i;
    logic [NumReq-1:0]       req_ready_o;
    logic [NumReq-1:0]       resp_valid_o;
    logic [Width-1:0]        resp_m_o;
    logic [NumReq-1:0]       resp_ready_i;

    modport master (
        output req_valid_i, req_a_i, req_b_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_m_o
    );

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_m_o
    );
endinterface

// File: rtl/mult_share_arbiter_rr.sv
// Round-robin grant search starting at the pointer, with wrap.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic         en,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic [W-1:0] nxt
);
    logic found;
    int   j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        nxt   = ptr;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
        if (en && found) begin
            gnt[idx] = 1'b1;
            nxt = (int'(idx) == N - 1) ? '0 : W'(int'(idx) + 1);
        end
    end
endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one signed fixed-point multiplier among NumReq requesters.
// MULT_SHARE_SATURATE_EN: clamp overflowing results and add sat_o.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int Width    = 16,
    parameter int InPoint  = 10,
    parameter int OutPoint = 10,
    parameter int NumReq   = 4
) (
    input  logic clk_i,
    input  logic rst_i,
`ifdef MULT_SHARE_SATURATE_EN
    output logic sat_o,
`endif
    mult_share_arbiter_if.slave bus
);
    localparam int IdxW = idx_w(NumReq);
    localparam int Lsb  = lsb_of(InPoint, OutPoint);
    localparam int PW   = 2 * Width;

    if (Lsb < 0 || Lsb > Width) begin : g_lsb_chk
        $error("mult_share_arbiter: LSB out of range");
    end
    if (NumReq < 2 || NumReq > 8) begin : g_req_chk
        $error("mult_share_arbiter: NumReq out of range");
    end

    logic                    s1_v, s2_v, s2_sat;
    logic signed [Width-1:0] s1_a, s1_b;
    logic [IdxW-1:0]         s1_idx, s2_idx;
    logic [Width-1:0]        s2_m;
    logic [IdxW-1:0]         ptr, ptr_nxt, gnt_idx;
    logic [NumReq-1:0]       gnt;
    logic                    stall, s1_en, acc;
    logic signed [PW-1:0]    prod;
    logic [Width-1:0]        res;
    logic                    ovf;
    logic [Width-1:0]        a_sel, b_sel;

    assign stall = s2_v && !bus.resp_ready_i[s2_idx];
    assign s1_en = !rst_i && (!s1_v || !stall);
    assign acc   = |gnt;

    rr_arbiter #(.N(NumReq)) u_arb (
        .req (bus.req_valid_i),
        .en  (s1_en),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .nxt (ptr_nxt)
    );

    assign bus.req_ready_o = gnt;
    assign a_sel = bus.req_a_i[int'(gnt_idx)*Width +: Width];
    assign b_sel = bus.req_b_i[int'(gnt_idx)*Width +: Width];

    assign prod = PW'(s1_a) * PW'(s1_b);

`ifdef MULT_SHARE_SATURATE_EN
    localparam logic [Width-1:0] MaxV = Width'(sat_max(Width));
    localparam logic [Width-1:0] MinV = Width'(sat_min(Width));
    logic [PW-Lsb-Width:0] hi;

    // Result fits only if the bits above it all match its sign bit.
    assign hi  = prod[PW-1:Lsb+Width-1];
    assign ovf = !(&hi || ~|hi);
    assign res = ovf ? (prod[PW-1] ? MinV : MaxV)
                     : prod[Lsb +: Width];
    assign sat_o = s2_v && s2_sat && bus.resp_ready_i[s2_idx];
`else
    logic unused_prod;

    assign unused_prod = ^{prod, s2_sat};
    assign ovf = 1'b0;
    assign res = prod[Lsb +: Width];
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr    <= '0;
            s1_v   <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_idx <= '0;
            s2_v   <= 1'b0;
            s2_m   <= '0;
            s2_idx <= '0;
            s2_sat <= 1'b0;
        end else begin
            ptr <= ptr_nxt;
            if (s1_en) begin
                s1_v <= acc;
                if (acc) begin
                    s1_a   <= a_sel;
                    s1_b   <= b_sel;
                    s1_idx <= gnt_idx;
                end
            end
            if (!stall) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_m   <= res;
                    s2_idx <= s1_idx;
                    s2_sat <= ovf;
                end
            end
        end
    end

    always_comb begin
        bus.resp_valid_o = '0;
        if (s2_v) bus.resp_valid_o[s2_idx] = 1'b1;
    end

    assign bus.resp_m_o = s2_m;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: vector table plus corner sequences.
module tb_mult_share_arbiter;
    localparam int W = 16;
    localparam int N = 4;

    typedef struct {
        logic [N-1:0]   v;
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
        logic [N-1:0]   er;
        logic [N-1:0]   ev;
        logic [W-1:0]   em;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
`ifdef MULT_SHARE_SATURATE_EN
    logic sat;
`endif

    mult_share_arbiter_if #(.Width(W), .NumReq(N)) bus ();

    mult_share_arbiter #(
        .Width(W), .InPoint(10), .OutPoint(10), .NumReq(N)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
`ifdef MULT_SHARE_SATURATE_EN
        .sat_o (sat),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [N*W-1:0] pk(
        input logic [W-1:0] v0, v1, v2, v3);
        return {v3, v2, v1, v0};
    endfunction

    function automatic vec_t mk(
        input logic [N-1:0] v, input logic [N*W-1:0] a, b,
        input logic [N-1:0] er, ev, input logic [W-1:0] em);
        vec_t r;
        r.v = v; r.a = a; r.b = b;
        r.er = er; r.ev = ev; r.em = em;
        return r;
    endfunction

    task automatic chk(input string nm,
                       input logic [W-1:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v,
                         input logic [N*W-1:0] a, b,
                         input logic [N-1:0] rdy);
        bus.req_valid_i  = v;
        bus.req_a_i      = a;
        bus.req_b_i      = b;
        bus.resp_ready_i = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [N-1:0] er,
                           input logic [N-1:0] ev,
                           input logic [W-1:0] em);
        chk({nm, " ready"}, 16'(bus.req_ready_o), 16'(er));
        chk({nm, " rvalid"}, 16'(bus.resp_valid_o), 16'(ev));
        if (ev != '0) chk({nm, " m"}, bus.resp_m_o, em);
    endtask

    task automatic one_op(input string nm, input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic [W-1:0] em, input logic es);
        drive(4'b0001, pk(a, 0, 0, 0), pk(b, 0, 0, 0), 4'hF);
        #2 chk_out({nm, " c0"}, 4'b0001, 4'b0000, 16'h0);
        step();
        drive(4'b0000, '0, '0, 4'hF);
        #2 chk_out({nm, " c1"}, 4'b0000, 4'b0000, 16'h0);
        step();
        #2 chk_out({nm, " c2"}, 4'b0000, 4'b0001, em);
`ifdef MULT_SHARE_SATURATE_EN
        chk({nm, " sat"}, 16'(sat), 16'(es));
`else
        if (es) $display("note: %s saturates only with macro", nm);
`endif
        step();
    endtask

    logic [N*W-1:0] ra, rb;

    initial begin
        ra = pk(16'h0400, 16'h0003, 16'h0200, 16'hFA00);
        rb = pk(16'h0C00, 16'hFFFD, 16'h0200, 16'hFC00);
        tbl.push_back(mk(4'b0001, pk(16'd1536, 0, 0, 0),
            pk(16'd2048, 0, 0, 0), 4'b0001, 4'b0000, 16'h0));
        tbl.push_back(mk(4'b0000, '0, '0, 4'b0000, 4'b0000, 16'h0));
        tbl.push_back(mk(4'b0000, '0, '0, 4'b0000, 4'b0001, 16'h0C00));
        tbl.push_back(mk(4'b0100, pk(0, 0, 16'hFE00, 0),
            pk(0, 0, 16'h0200, 0), 4'b0100, 4'b0000, 16'h0));
        tbl.push_back(mk(4'b0000, '0, '0, 4'b0000, 4'b0000, 16'h0));
        tbl.push_back(mk(4'b0000, '0, '0, 4'b0000, 4'b0100, 16'hFF00));
        tbl.push_back(mk(4'b1000, pk(0, 0, 0, 16'h0400),
            pk(0, 0, 0, 16'h0400), 4'b1000, 4'b0000, 16'h0));
        tbl.push_back(mk(4'hF, ra, rb, 4'b0001, 4'b0000, 16'h0));
        tbl.push_back(mk(4'hF, ra, rb, 4'b0010, 4'b1000, 16'h0400));
        tbl.push_back(mk(4'hF, ra, rb, 4'b0100, 4'b0001, 16'h0C00));
        tbl.push_back(mk(4'hF, ra, rb, 4'b1000, 4'b0010, 16'hFFFF));
        tbl.push_back(mk(4'hF, ra, rb, 4'b0001, 4'b0100, 16'h0100));
        tbl.push_back(mk(4'hF, ra, rb, 4'b0010, 4'b1000, 16'h0600));
        tbl.push_back(mk(4'b0000, '0, '0, 4'b0000, 4'b0001, 16'h0C00));
        tbl.push_back(mk(4'b0000, '0, '0, 4'b0000, 4'b0010, 16'hFFFF));
        tbl.push_back(mk(4'b0000, '0, '0, 4'b0000, 4'b0000, 16'h0));

        // Reset state, with requests pending to prove ready is held low.
        drive(4'hF, ra, rb, 4'hF);
        #3 chk_out("reset", 4'b0000, 4'b0000, 16'h0);
        chk("reset m", bus.resp_m_o, 16'h0);
        drive(4'h0, '0, '0, 4'hF);
        step();
        rst = 1'b0;
        step();

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].b, 4'hF);
            #2 chk_out($sformatf("row%0d", i),
                       tbl[i].er, tbl[i].ev, tbl[i].em);
            step();
        end

        // Backpressure: req1 result stalled, req3 waits behind it.
        drive(4'b0010, pk(0, 16'h0400, 0, 0), pk(0, 16'h0800, 0, 0), 4'hF);
        #2 chk_out("bp a", 4'b0010, 4'b0000, 16'h0);
        step();
        drive(4'b0000, '0, '0, 4'hF);
        #2 chk_out("bp b", 4'b0000, 4'b0000, 16'h0);
        step();
        drive(4'b1000, pk(0, 0, 0, 16'h0400), pk(0, 0, 0, 16'h0200), 4'b1101);
        #2 chk_out("bp c", 4'b1000, 4'b0010, 16'h0800);
        step();
        #2 chk_out("bp d", 4'b0000, 4'b0010, 16'h0800);
        step();
        #2 chk_out("bp e", 4'b0000, 4'b0010, 16'h0800);
        step();
        drive(4'b0000, '0, '0, 4'hF);
        #2 chk_out("bp f", 4'b0000, 4'b0010, 16'h0800);
        step();
        #2 chk_out("bp g", 4'b0000, 4'b1000, 16'h0200);
        step();
        #2 chk_out("bp h", 4'b0000, 4'b0000, 16'h0);
        step();

        // Overflow: 20.0 * 20.0 and -20.0 * 20.0.
`ifdef MULT_SHARE_SATURATE_EN
        one_op("ovf pos", 16'd20480, 16'd20480, 16'h7FFF, 1'b1);
        one_op("ovf neg", 16'hB000, 16'd20480, 16'h8000, 1'b1);
`else
        one_op("ovf pos", 16'd20480, 16'd20480, 16'h4000, 1'b0);
        one_op("ovf neg", 16'hB000, 16'd20480, 16'hC000, 1'b0);
`endif

        // Reset with S1 and S2 both occupied.
        drive(4'b0010, pk(0, 16'h0400, 0, 0), pk(0, 16'h0400, 0, 0), 4'hF);
        #2 chk_out("rm x", 4'b0010, 4'b0000, 16'h0);
        step();
        drive(4'b0100, pk(0, 0, 16'h0400, 0), pk(0, 0, 16'h0400, 0), 4'hF);
        #2 chk_out("rm y", 4'b0100, 4'b0000, 16'h0);
        step();
        drive(4'b0000, '0, '0, 4'hF);
        #2 chk_out("rm z", 4'b0000, 4'b0010, 16'h0400);
        #1 rst = 1'b1;
        drive(4'hF, ra, rb, 4'hF);
        #1 chk_out("rm async", 4'b0000, 4'b0000, 16'h0);
        chk("rm async m", bus.resp_m_o, 16'h0);
        drive(4'b0000, '0, '0, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        step();
        #2 chk_out("rm post1", 4'b0000, 4'b0000, 16'h0);
        step();
        #2 chk_out("rm post2", 4'b0000, 4'b0000, 16'h0);
        drive(4'b1100, pk(0, 0, 16'h0600, 16'h0400),
              pk(0, 0, 16'h0400, 16'h0400), 4'hF);
        #1 chk_out("rm grant", 4'b0100, 4'b0000, 16'h0);
        step();
        drive(4'b0000, '0, '0, 4'hF);
        step();
        #2 chk_out("rm res", 4'b0000, 4'b0100, 16'h0600);
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
